// File: rtl/stream_buffer_flushable.sv
// Flushable stream buffer: a two-slot spill register for Depth==2, a circular
// FIFO with status counter for larger depths. Never fall-through.
module stream_buffer_flushable #(
    parameter int unsigned Depth     = 8,
    parameter type         type_t    = logic,
    parameter bit          PrintInfo = 1'b0,
    parameter int unsigned AddrDepth = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 testmode_i,
    output logic [AddrDepth-1:0] usage_o,
    input  type_t                data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output type_t                data_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    // Handshake: a beat is pushed at a rising edge when valid_i & ready_o and
    // popped when valid_o & ready_i. ready_o/valid_o depend only on registered
    // state; the source must not raise valid_i while ready_o is low, nor the
    // sink ready_i while valid_o is low.
    logic w_push;
    logic w_pop;
    logic w_unused_testmode;

    assign w_push            = valid_i & ready_o;
    assign w_pop             = valid_o & ready_i;
    assign w_unused_testmode = testmode_i;

    if (Depth < 2) begin : g_bad_depth
        $fatal(1, "stream_buffer_flushable: Depth must be at least 2 (got %0d)", Depth);
    end

    if (PrintInfo) begin : g_print_info
        if (Depth == 2) begin : g_info_spill
            $info("stream_buffer_flushable: spill register, Depth=%0d", Depth);
        end else begin : g_info_fifo
            $info("stream_buffer_flushable: circular FIFO, Depth=%0d", Depth);
        end
    end

    if (Depth == 2) begin : g_spill
        logic  r_a_full;
        logic  r_b_full;
        type_t r_a_data;
        type_t r_b_data;
        logic  w_a_leaves;
        logic  w_a_to_b;

        // With B empty, a full A always vacates: popped if ready_i, else moved to B.
        assign w_a_leaves = r_a_full & ~r_b_full;
        assign w_a_to_b   = r_a_full & ~r_b_full & ~ready_i;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_a_full <= 1'b0;
                r_b_full <= 1'b0;
                r_a_data <= '0;
                r_b_data <= '0;
            end else if (flush_i) begin
                r_a_full <= 1'b0;
                r_b_full <= 1'b0;
            end else begin
                if (w_push) begin
                    r_a_full <= 1'b1;
                    r_a_data <= data_i;
                end else if (w_a_leaves) begin
                    r_a_full <= 1'b0;
                end

                if (r_b_full && w_pop) begin
                    r_b_full <= 1'b0;
                end else if (w_a_to_b) begin
                    r_b_full <= 1'b1;
                    r_b_data <= r_a_data;
                end
            end
        end

        assign ready_o = ~(r_a_full & r_b_full);
        assign valid_o = r_a_full | r_b_full;
        assign data_o  = r_b_full ? r_b_data : r_a_data;
        assign usage_o = '0;
    end else begin : g_fifo
        localparam logic [AddrDepth-1:0] LastIdx   = AddrDepth'(Depth - 1);
        localparam logic [AddrDepth:0]   FullCount = (AddrDepth + 1)'(Depth);

        logic [AddrDepth-1:0] r_rd_ptr;
        logic [AddrDepth-1:0] r_wr_ptr;
        logic [AddrDepth:0]   r_count;
        type_t                r_mem [Depth];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
                for (int i = 0; i < Depth; i++) begin
                    r_mem[i] <= '0;
                end
            end else if (flush_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= data_i;
                    r_wr_ptr        <= (r_wr_ptr == LastIdx) ? '0 : r_wr_ptr + AddrDepth'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= (r_rd_ptr == LastIdx) ? '0 : r_rd_ptr + AddrDepth'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (AddrDepth + 1)'(1);
                    2'b01:   r_count <= r_count - (AddrDepth + 1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end

        assign ready_o = (r_count != FullCount);
        assign valid_o = (r_count != '0);
        assign data_o  = r_mem[r_rd_ptr];
        // Truncation is deliberate: a full power-of-two FIFO reads back 0.
        assign usage_o = r_count[AddrDepth-1:0];
    end

    a_no_push_when_full : assert property (
        @(posedge clk_i) disable iff (!rst_ni) valid_i |-> ready_o
    ) else $error("stream_buffer_flushable: valid_i asserted while ready_o low");

    a_no_pop_when_empty : assert property (
        @(posedge clk_i) disable iff (!rst_ni) ready_i |-> valid_o
    ) else $error("stream_buffer_flushable: ready_i asserted while valid_o low");

endmodule

// File: tb/tb_stream_buffer_flushable.sv
// Directed bench for stream_buffer_flushable at Depth 8, 2, 5, 4 and 3.
module tb_stream_buffer_flushable;

    typedef logic [7:0] byte_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic       f8 = 1'b0, v8 = 1'b0, r8 = 1'b0;
    byte_t      d8 = '0;
    logic [2:0] u8_usage;
    logic       u8_ready, u8_valid;
    byte_t      u8_data;

    logic       f2 = 1'b0, v2 = 1'b0, r2 = 1'b0;
    byte_t      d2 = '0;
    logic [0:0] u2_usage;
    logic       u2_ready, u2_valid;
    byte_t      u2_data;

    logic       f5 = 1'b0, v5 = 1'b0, r5 = 1'b0;
    byte_t      d5 = '0;
    logic [2:0] u5_usage;
    logic       u5_ready, u5_valid;
    byte_t      u5_data;

    logic       f4 = 1'b0, v4 = 1'b0, r4 = 1'b0;
    byte_t      d4 = '0;
    logic [1:0] u4_usage;
    logic       u4_ready, u4_valid;
    byte_t      u4_data;

    logic       f3 = 1'b0, v3 = 1'b0, r3 = 1'b0;
    byte_t      d3 = '0;
    logic [1:0] u3_usage;
    logic       u3_ready, u3_valid;
    byte_t      u3_data;

    stream_buffer_flushable #(.Depth(8), .type_t(byte_t)) u_d8 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f8), .testmode_i(1'b0), .usage_o(u8_usage),
        .data_i(d8), .valid_i(v8), .ready_o(u8_ready), .data_o(u8_data), .valid_o(u8_valid),
        .ready_i(r8)
    );
    stream_buffer_flushable #(.Depth(2), .type_t(byte_t)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f2), .testmode_i(1'b0), .usage_o(u2_usage),
        .data_i(d2), .valid_i(v2), .ready_o(u2_ready), .data_o(u2_data), .valid_o(u2_valid),
        .ready_i(r2)
    );
    stream_buffer_flushable #(.Depth(5), .type_t(byte_t)) u_d5 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f5), .testmode_i(1'b0), .usage_o(u5_usage),
        .data_i(d5), .valid_i(v5), .ready_o(u5_ready), .data_o(u5_data), .valid_o(u5_valid),
        .ready_i(r5)
    );
    stream_buffer_flushable #(.Depth(4), .type_t(byte_t)) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f4), .testmode_i(1'b0), .usage_o(u4_usage),
        .data_i(d4), .valid_i(v4), .ready_o(u4_ready), .data_o(u4_data), .valid_o(u4_valid),
        .ready_i(r4)
    );
    stream_buffer_flushable #(.Depth(3), .type_t(byte_t)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f3), .testmode_i(1'b0), .usage_o(u3_usage),
        .data_i(d3), .valid_i(v3), .ready_o(u3_ready), .data_o(u3_data), .valid_o(u3_valid),
        .ready_i(r3)
    );

    task automatic test_reset();
        #12;
        checks++;
        if (u8_valid !== 1'b0 || u8_ready !== 1'b1 || u8_usage !== 3'd0 || u8_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_d8 got v=%b r=%b u=%0d d=%0d want v=0 r=1 u=0 d=0",
                     u8_valid, u8_ready, u8_usage, u8_data);
        end
        checks++;
        if (u2_valid !== 1'b0 || u2_ready !== 1'b1 || u2_usage !== 1'b0 || u2_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_d2 got v=%b r=%b u=%0d d=%0d want v=0 r=1 u=0 d=0",
                     u2_valid, u2_ready, u2_usage, u2_data);
        end
        checks++;
        if (u5_valid !== 1'b0 || u5_ready !== 1'b1 || u5_usage !== 3'd0 || u5_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_d5 got v=%b r=%b u=%0d d=%0d want v=0 r=1 u=0 d=0",
                     u5_valid, u5_ready, u5_usage, u5_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill_wrap();
        @(negedge clk);
        checks++;
        if (u8_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_empty_valid got %b want 0", u8_valid);
        end
        for (int k = 1; k <= 8; k++) begin
            v8 = 1'b1;
            d8 = byte_t'(k);
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (u8_valid !== 1'b1 || u8_usage !== 3'd1) begin
                    errors++;
                    $display("FAIL fill_first_push got v=%b u=%0d want v=1 u=1", u8_valid, u8_usage);
                end
            end
        end
        v8 = 1'b0;
        checks++;
        if (u8_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full_ready got %b want 0", u8_ready);
        end
        checks++;
        if (u8_usage !== 3'd0) begin
            errors++;
            $display("FAIL fill_wrap_usage got %0d want 0", u8_usage);
        end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (u8_data !== byte_t'(k) || u8_valid !== 1'b1) begin
                errors++;
                $display("FAIL fill_pop_order got d=%0d v=%b want d=%0d v=1", u8_data, u8_valid, k);
            end
            r8 = 1'b1;
            @(negedge clk);
        end
        r8 = 1'b0;
        checks++;
        if (u8_valid !== 1'b0 || u8_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_drained got v=%b r=%b want v=0 r=1", u8_valid, u8_ready);
        end
    endtask

    task automatic test_spill();
        int accepted;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                checks++;
                if (u2_data !== byte_t'(10 + i - 1) || u2_valid !== 1'b1 || u2_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL spill_stream got d=%0d v=%b r=%b want d=%0d v=1 r=1",
                             u2_data, u2_valid, u2_ready, 10 + i - 1);
                end
            end
            v2 = 1'b1;
            d2 = byte_t'(10 + i);
            r2 = u2_valid;
            @(negedge clk);
        end
        v2 = 1'b0;
        checks++;
        if (u2_data !== 8'd15 || u2_valid !== 1'b1) begin
            errors++;
            $display("FAIL spill_last got d=%0d v=%b want d=15 v=1", u2_data, u2_valid);
        end
        r2 = u2_valid;
        @(negedge clk);
        r2 = 1'b0;
        checks++;
        if (u2_valid !== 1'b0) begin
            errors++;
            $display("FAIL spill_empty got v=%b want 0", u2_valid);
        end

        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            v2 = u2_ready;
            d2 = byte_t'(20 + accepted);
            if (u2_ready) accepted++;
            @(negedge clk);
        end
        v2 = 1'b0;
        checks++;
        if (accepted != 2 || u2_ready !== 1'b0) begin
            errors++;
            $display("FAIL spill_stall got accepted=%0d r=%b want accepted=2 r=0", accepted, u2_ready);
        end
        checks++;
        if (u2_data !== 8'd20 || u2_valid !== 1'b1 || u2_usage !== 1'b0) begin
            errors++;
            $display("FAIL spill_hold got d=%0d v=%b u=%0d want d=20 v=1 u=0", u2_data, u2_valid, u2_usage);
        end
        r2 = 1'b1;
        @(negedge clk);
        checks++;
        if (u2_data !== 8'd21 || u2_valid !== 1'b1 || u2_ready !== 1'b1) begin
            errors++;
            $display("FAIL spill_drain got d=%0d v=%b r=%b want d=21 v=1 r=1", u2_data, u2_valid, u2_ready);
        end
        @(negedge clk);
        r2 = 1'b0;

        v2 = 1'b1;
        d2 = 8'd70;
        @(negedge clk);
        f2 = 1'b1;
        d2 = 8'd71;
        @(negedge clk);
        f2 = 1'b0;
        v2 = 1'b0;
        checks++;
        if (u2_valid !== 1'b0 || u2_ready !== 1'b1) begin
            errors++;
            $display("FAIL spill_flush got v=%b r=%b want v=0 r=1", u2_valid, u2_ready);
        end
    endtask

    task automatic test_concurrent();
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            v5 = 1'b1;
            d5 = byte_t'(k);
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (u5_usage !== 3'd3 || u5_data !== byte_t'(i + 1)) begin
                errors++;
                $display("FAIL conc_step got u=%0d d=%0d want u=3 d=%0d", u5_usage, u5_data, i + 1);
            end
            v5 = 1'b1;
            d5 = byte_t'(4 + i);
            r5 = 1'b1;
            @(negedge clk);
        end
        v5 = 1'b0;
        for (int k = 11; k <= 13; k++) begin
            checks++;
            if (u5_data !== byte_t'(k) || u5_valid !== 1'b1) begin
                errors++;
                $display("FAIL conc_drain got d=%0d v=%b want d=%0d v=1", u5_data, u5_valid, k);
            end
            r5 = 1'b1;
            @(negedge clk);
        end
        r5 = 1'b0;
        checks++;
        if (u5_valid !== 1'b0 || u5_usage !== 3'd0) begin
            errors++;
            $display("FAIL conc_empty got v=%b u=%0d want v=0 u=0", u5_valid, u5_usage);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        for (int k = 31; k <= 33; k++) begin
            v4 = 1'b1;
            d4 = byte_t'(k);
            @(negedge clk);
        end
        checks++;
        if (u4_usage !== 2'd3 || u4_data !== 8'd31) begin
            errors++;
            $display("FAIL flush_prefill got u=%0d d=%0d want u=3 d=31", u4_usage, u4_data);
        end
        f4 = 1'b1;
        d4 = 8'd99;
        @(negedge clk);
        f4 = 1'b0;
        v4 = 1'b0;
        checks++;
        if (u4_valid !== 1'b0 || u4_usage !== 2'd0 || u4_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear got v=%b u=%0d r=%b want v=0 u=0 r=1", u4_valid, u4_usage, u4_ready);
        end
        v4 = 1'b1;
        d4 = 8'd40;
        @(negedge clk);
        v4 = 1'b0;
        checks++;
        if (u4_data !== 8'd40 || u4_usage !== 2'd1 || u4_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_after got d=%0d u=%0d v=%b want d=40 u=1 v=1", u4_data, u4_usage, u4_valid);
        end
        r4 = 1'b1;
        @(negedge clk);
        r4 = 1'b0;
        checks++;
        if (u4_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_ghost got v=%b d=%0d want v=0", u4_valid, u4_data);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        v3 = 1'b1;
        d3 = 8'd51;
        @(negedge clk);
        d3 = 8'd52;
        @(negedge clk);
        v3 = 1'b0;
        checks++;
        if (u3_usage !== 2'd2 || u3_data !== 8'd51) begin
            errors++;
            $display("FAIL areset_prefill got u=%0d d=%0d want u=2 d=51", u3_usage, u3_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (u3_valid !== 1'b0 || u3_ready !== 1'b1 || u3_usage !== 2'd0 || u3_data !== 8'd0) begin
            errors++;
            $display("FAIL areset_immediate got v=%b r=%b u=%0d d=%0d want v=0 r=1 u=0 d=0",
                     u3_valid, u3_ready, u3_usage, u3_data);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        v3 = 1'b1;
        d3 = 8'd60;
        @(negedge clk);
        v3 = 1'b0;
        checks++;
        if (u3_data !== 8'd60 || u3_valid !== 1'b1 || u3_usage !== 2'd1) begin
            errors++;
            $display("FAIL areset_new_data got d=%0d v=%b u=%0d want d=60 v=1 u=1", u3_data, u3_valid, u3_usage);
        end
        r3 = 1'b1;
        @(negedge clk);
        r3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_wrap();
        test_spill();
        test_concurrent();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
